// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by both ends of the serial link.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // 16 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 139;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle.
// Byte, strobes and busy flag.
interface uart_rx_if
  import uart_pkg::*;
();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for async inputs.
// Reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // metastability filter: d -> s1 -> q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
// Mid-bit sampling, break detect.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST =
    3'(DATA_BITS - 1);

  logic                 rx_s;

  rx_state_e            state;
  rx_state_e            state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [2:0]           idx;
  logic [2:0]           idx_n;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] sh_n;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_q;
  logic                 valid_n;
  logic                 ferr_q;
  logic                 ferr_n;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // state, counters, shifter and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  // next state; strobes default low
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          idx_n = '0;
          // line back high: glitch, not a start
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
          end
        end
      end

      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          // LSB arrives first, ends in bit 0
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = sh;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end

      BREAK: begin
        // hold off until the line idles
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Scoreboard of expected bytes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 8;
  localparam int BIT_NS = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int fcnt  = 0;
  int cyc   = 0;
  int vcyc  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: pop scoreboard on valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid || bus.frame_err) begin
        tests++;
        if (bus.valid && bus.frame_err) begin
          fails++;
          $display("FAIL strobe_overlap: valid=1 frame_err=1, required not both");
        end
      end
      if (bus.valid) begin
        vcnt++;
        vcyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: data=%h, required no valid", bus.data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.data !== mon_e) begin
            fails++;
            $display("FAIL rx_data: got %h, required %h", bus.data, mon_e);
          end
        end
      end
      if (bus.frame_err) fcnt++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stopb, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stopb;
    #(bit_ns);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d bytes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %h, required 00", bus.data);
    end
    tests++;
    if (bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b, required 0", bus.valid);
    end
    tests++;
    if (bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ferr: got %b, required 0", bus.frame_err);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int v0;
    int f0;
    v0 = vcnt;
    f0 = fcnt;
    @(posedge clk);
    #1;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, BIT_NS);
    end
    wait_drain("b2b", 200);
    repeat (10) @(posedge clk);
    tests++;
    if (vcnt - v0 != 256) begin
      fails++;
      $display("FAIL b2b_count: got %0d valids, required 256", vcnt - v0);
    end
    tests++;
    if (fcnt != f0) begin
      fails++;
      $display("FAIL b2b_ferr: got %0d frame_err, required 0", fcnt - f0);
    end
  endtask

  task automatic test_latency();
    int c0;
    int lat;
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NS);
    wait_drain("lat", 200);
    lat = vcyc - (c0 + 1);
    tests++;
    if (lat < 78 || lat > 80) begin
      fails++;
      $display("FAIL latency: got %0d cycles, required 79 +/- 1", lat);
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_frame_err();
    int v0;
    int f0;
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h55, 1'b0, BIT_NS);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("ferr_count", 32'(fcnt - f0), 32'd1);
    chk("ferr_novalid", 32'(vcnt - v0), 32'd0);
    chk("ferr_data_kept", {24'd0, bus.data}, 32'h5A);
    chk("ferr_busy_low_line", {31'd0, bus.busy}, 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_busy_release", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    v0 = vcnt;
    f0 = fcnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'd0, bus.busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", {31'd0, bus.busy}, 32'd0);
    chk("glitch_novalid", 32'(vcnt - v0), 32'd0);
    chk("glitch_noferr", 32'(fcnt - f0), 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int f0;
    b = 8'hA5;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_data", {24'd0, bus.data}, 32'h00);
    chk("rstmid_valid", {31'd0, bus.valid}, 32'd0);
    chk("rstmid_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    f0 = fcnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    wait_drain("rstmid", 200);
    chk("rstmid_noferr", 32'(fcnt - f0), 32'd0);
    repeat (10) @(posedge clk);
  endtask

  task automatic test_skew();
    int f0;
    f0 = fcnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 83);
    wait_drain("skew", 200);
    chk("skew_noferr", 32'(fcnt - f0), 32'd0);
    repeat (10) @(posedge clk);
  endtask

  task automatic test_break();
    int v0;
    int f0;
    v0 = vcnt;
    f0 = fcnt;
    rx = 1'b0;
    #(3 * 10 * BIT_NS);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("break_ferr", 32'(fcnt - f0), 32'd1);
    chk("break_novalid", 32'(vcnt - v0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    wait_drain("break", 200);
    chk("break_ferr_after", 32'(fcnt - f0), 32'd1);
    repeat (10) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_latency();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_skew();
    test_break();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
